// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a per-register busy (pending producer) scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and next-state busy bits to the read ports.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                busy_set,
    input  logic [AW-1:0]       busy_addr,
    output logic [NRD-1:0]      rd_busy,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;

    // Later ports overwrite earlier ones, so the highest-index port wins on an address clash.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && (wa[i*AW +: AW] != '0)) begin
                mem_d[wa[i*AW +: AW]]  = wd[i*XLEN +: XLEN];
                busy_d[wa[i*AW +: AW]] = 1'b0;
            end
        end
        // Set after clear: a new producer issued in the same cycle keeps the register busy.
        if (busy_set && (busy_addr != '0)) begin
            busy_d[busy_addr] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ra[p*AW +: AW] != '0) begin
                rd[p*XLEN +: XLEN] = mem_q[ra[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int i = 0; i < NWR; i++) begin
                    if (we[i] && (wa[i*AW +: AW] == ra[p*AW +: AW])) begin
                        rd[p*XLEN +: XLEN] = wd[i*XLEN +: XLEN];
                    end
                end
                rd_busy[p] = busy_d[ra[p*AW +: AW]];
`else
                rd_busy[p] = busy_q[ra[p*AW +: AW]];
`endif
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: an array-based reference model checked every cycle, plus directed literal checks.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic [NRD-1:0]      rd_busy;
    logic [AW:0]         busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .busy_set(busy_set), .busy_addr(busy_addr), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values and busy flags.
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_busy [NREGS];
    bit              started = 1'b0;

    function automatic int count_busy();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Value a reader at address a must see this cycle.
    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++)
            if (we[i] && wa[i*AW +: AW] == a) v = wd[i*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        bit b;
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++)
            if (we[i] && wa[i*AW +: AW] == a) b = 1'b0;
        if (busy_set && busy_addr == a) b = 1'b1;
`endif
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
            started = 1'b1;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && wa[i*AW +: AW] != 0) begin
                    m_reg[wa[i*AW +: AW]]  = wd[i*XLEN +: XLEN];
                    m_busy[wa[i*AW +: AW]] = 1'b0;
                end
            end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("model rd[%0d]", p), rd[p*XLEN +: XLEN],
                      exp_read(ra[p*AW +: AW]));
                check($sformatf("model rd_busy[%0d]", p), 32'(rd_busy[p]),
                      32'(exp_busy(ra[p*AW +: AW])));
            end
            check("model busy_cnt", 32'(busy_cnt), 32'(count_busy()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        we       = '0;
        busy_set = 1'b0;
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; busy_set = 1'b0; busy_addr = '0;
        read2(5, 5);
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("reset rd0", rd[31:0], 32'h0);
        check("reset rd1", rd[63:32], 32'h0);
        check("reset rd_busy", 32'(rd_busy), 32'h0);
        check("reset busy_cnt", 32'(busy_cnt), 32'h0);

        // Both write ports hit x7; port 1 must win.
        step();
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        step();
        read2(7, 7);
        @(negedge clk);
        check("clash rd0", rd[31:0], 32'hBBBB_BBBB);
        check("clash rd1", rd[63:32], 32'hBBBB_BBBB);

        // x0 ignores writes and busy marks.
        step();
        we = 2'b01; wa = '0; wd = {32'h0, 32'hDEAD_BEEF}; busy_set = 1'b1; busy_addr = 0;
        read2(0, 0);
        @(negedge clk);
        check("x0 same-cycle rd", rd[31:0], 32'h0);
        step();
        @(negedge clk);
        check("x0 rd", rd[31:0], 32'h0);
        check("x0 rd_busy", 32'(rd_busy), 32'h0);
        check("x0 busy_cnt", 32'(busy_cnt), 32'h0);

        // Mark x3 busy, then set and write it in one cycle: stays busy.
        step();
        busy_set = 1'b1; busy_addr = 3;
        read2(3, 3);
        step();
        @(negedge clk);
        check("x3 busy", 32'(rd_busy[0]), 32'h1);
        check("x3 busy_cnt", 32'(busy_cnt), 32'h1);
        step();
        busy_set = 1'b1; busy_addr = 3;
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h0000_0055};
        step();
        @(negedge clk);
        check("x3 set-wins busy", 32'(rd_busy[0]), 32'h1);
        check("x3 set-wins cnt", 32'(busy_cnt), 32'h1);
        check("x3 data", rd[31:0], 32'h0000_0055);

        // Same-cycle write/read of x9.
        step();
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h0000_1234};
        read2(9, 9);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("x9 same-cycle", rd[31:0], 32'h0000_1234);
`else
        check("x9 same-cycle", rd[31:0], 32'h0);
`endif
        step();
        @(negedge clk);
        check("x9 next-cycle", rd[31:0], 32'h0000_1234);

        // Busy x1..x4 (x3 already busy) then reset discards them all.
        for (int k = 1; k <= 4; k++) begin
            step();
            busy_set = 1'b1; busy_addr = AW'(k);
        end
        step();
        read2(1, 2);
        @(negedge clk);
        check("pre-reset busy_cnt", 32'(busy_cnt), 32'd4);
        check("pre-reset rd_busy", 32'(rd_busy), 32'h3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post-reset busy_cnt", 32'(busy_cnt), 32'h0);
        check("post-reset rd_busy", 32'(rd_busy), 32'h0);
        check("post-reset rd", rd[31:0], 32'h0);

        // Mixed traffic over a narrow address range to provoke clashes; checked by the model.
        for (int c = 0; c < 60; c++) begin
            step();
            we        = NWR'($urandom);
            wa        = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wd        = {$urandom, $urandom};
            busy_set  = 1'($urandom);
            busy_addr = AW'($urandom_range(0, 7));
            read2(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
